reduction_self_check: RTL and testbench
=======================================

// Module: reduction_self_check
// PURPOSE
//  Parametrised self-checking engine for wide AND/OR (optional XOR) reduction logic.
//  On start, it streams WIDTH+2 deterministic patterns through a pattern register.
//  Each pattern's reduction results are compared against independent equality and parity references.
//  Mismatches are counted and summarised.
//  Sits beside datapath reduction trees as a built-in check, driven by the test/control block.
// PARAMETERS
//  WIDTH  68  pattern/reduction width in bits (>=1)
//  ERR_W  8   width of saturating mismatch counter (>=1)
//  IDX_W  $clog2(WIDTH+2)  pattern index width (localparam, derived)
// PORTS
//  clock            input   1      single clock; all state updates on posedge
//  reset            input   1      asynchronous, active-low reset
//  start            input   1      begin a run; sampled only in IDLE
//  inject           input   1      fault injection; inverts AND-reference of pattern issued this cycle
//  busy             output  1      high from cycle after start until done pulse inclusive
//  done             output  1      one-cycle pulse at end of run
//  pass             output  1      valid with done, held until next start: err_count==0
//  err_count        output  ERR_W  mismatches this run, saturating at all-ones
//  first_err_valid  output  1      a mismatch has been recorded this run
//  first_err_idx    output  IDX_W  pattern index of first mismatch
// BEHAVIOUR
//  Reset (reset==0, async): FSM=IDLE; all outputs, pattern reg and pipeline cleared to 0.
//  Patterns, k = 0..WIDTH+1 (N = WIDTH+2):
//   k=0: all zeros. k=1..WIDTH: all ones with bit k-1 cleared. k=WIDTH+1: all ones.
//  FSM: IDLE -start-> GEN; GEN issues one pattern/cycle, k=0..N-1, then DRAIN.
//   DRAIN lasts 2 cycles, then DONE (1 cycle, done=1), then IDLE.
//  Pipeline:
//   S0: pattern reg r (+ injected flag).
//   S1: registered and_r=&r, or_r=|r, ref_all1=(r=={WIDTH{1}})^inj, ref_nz=(r!=0).
//   S2: mismatch=(and_r!=ref_all1)|(or_r!=ref_nz); update counters.
//  Latency: start sampled at cycle 0. Pattern k is in r at cycle k+1 and compared at k+3.
//   done=1 at cycle N+3. busy=1 on cycles 1..N+3.
//  On start: err_count, first_err_valid, first_err_idx and pass clear in the same edge.
//  err_count: +1 per mismatching pattern (one per pattern even if several checks fail).
//   Holds at {ERR_W{1}}; never wraps.
//  first_err_idx latches on the first mismatch only; later mismatches do not update it.
//  pass updates only at the done edge and holds until the next start.
//  start while busy: ignored, no restart. start held high: new run begins the cycle after DONE.
//  inject is sampled only in GEN; ignored in IDLE/DRAIN/DONE.
//  Reset mid-run: immediate abort to reset values. No done pulse; next run needs a fresh start.
//  WIDTH=1: patterns are 0, 0, 1 (k=1 clears the only bit); all checks remain valid.
// CONFIGURATION
//  REDCHK_XOR_EN defined:
//   S1 adds xor_r=^r and ref_par = popcount(r)[0] (adder-based, independent of the XOR tree).
//   S2 mismatch also ORs (xor_r!=ref_par).
//  REDCHK_XOR_EN undefined: no XOR or popcount logic; ports and timing unchanged.
// TESTING
//  WIDTH=68, start pulse, inject=0 -> done at cycle 73; pass=1, err_count=0, first_err_valid=0.
//  WIDTH=68, inject=1 on cycle of k=69 (all ones) -> err_count=1, first_err_idx=69, pass=0.
//  ERR_W=2, WIDTH=8, inject held 1 through GEN -> err_count saturates at 3.
//   first_err_idx=0, pass=0.
//  WIDTH=68, reset low at cycle 20 of a run -> all outputs 0 asynchronously, no done.
//   Fresh start then gives pass=1.
//  Start re-pulsed at cycles 5 and 40 during a run -> ignored; single done at cycle 73.
//  WIDTH=1 with REDCHK_XOR_EN -> done at cycle 6, pass=1; repeat with inject on k=2 -> err_count=1.

Source files
------------

// File: rtl/reduction_self_check.sv
// Self-checking engine that streams WIDTH+2 deterministic patterns through wide AND/OR
// reductions and counts disagreements with equality references. Define REDCHK_XOR_EN to add an XOR/parity check.
module reduction_self_check #(
  parameter  int WIDTH = 68,
  parameter  int ERR_W = 8,
  localparam int IDX_W = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             inject,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [IDX_W-1:0] first_err_idx
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH + 1);

  // k=0 all zeros, k=1..WIDTH all ones with bit k-1 cleared, k=WIDTH+1 all ones
  function automatic logic [WIDTH-1:0] pattern_of(input logic [IDX_W-1:0] k);
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) begin
      p[i] = (k != {IDX_W{1'b0}}) && (k != IDX_W'(i + 1));
    end
    return p;
  endfunction

`ifdef REDCHK_XOR_EN
  // Parity reference from an adder chain, so it shares no structure with the ^ tree
  function automatic logic popcount_lsb(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] cnt;
    cnt = {IDX_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + IDX_W'(v[i]);
    end
    return cnt[0];
  endfunction
`endif

  state_t           state_r;
  logic [WIDTH-1:0] pat_r;
  logic [IDX_W-1:0] pat_idx_r;
  logic             pat_vld_r;
  logic             drain_r;

  logic             s1_vld_r;
  logic [IDX_W-1:0] s1_idx_r;
  logic             and_r;
  logic             or_r;
  logic             ref_all1_r;
  logic             ref_nz_r;
`ifdef REDCHK_XOR_EN
  logic             xor_r;
  logic             ref_par_r;
`endif

  logic             inj_s;
  logic             mismatch_s;

  // inject applies to the pattern currently held in the pattern register during GEN
  assign inj_s = inject && (state_r == GEN);

  // Sequencer: issues patterns, then drains the pipeline before the done pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      pat_r     <= {WIDTH{1'b0}};
      pat_idx_r <= {IDX_W{1'b0}};
      pat_vld_r <= 1'b0;
      drain_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= GEN;
            pat_r     <= pattern_of({IDX_W{1'b0}});
            pat_idx_r <= {IDX_W{1'b0}};
            pat_vld_r <= 1'b1;
            busy      <= 1'b1;
          end else begin
            pat_vld_r <= 1'b0;
            busy      <= 1'b0;
          end
        end
        GEN: begin
          if (pat_idx_r == LAST_IDX) begin
            state_r   <= DRAIN;
            pat_vld_r <= 1'b0;
            drain_r   <= 1'b0;
          end else begin
            pat_r     <= pattern_of(pat_idx_r + {{(IDX_W-1){1'b0}}, 1'b1});
            pat_idx_r <= pat_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            pat_vld_r <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_r) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            drain_r <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          pat_vld_r <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: reductions under test alongside their independent references
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_vld_r   <= 1'b0;
      s1_idx_r   <= {IDX_W{1'b0}};
      and_r      <= 1'b0;
      or_r       <= 1'b0;
      ref_all1_r <= 1'b0;
      ref_nz_r   <= 1'b0;
`ifdef REDCHK_XOR_EN
      xor_r      <= 1'b0;
      ref_par_r  <= 1'b0;
`endif
    end else begin
      s1_vld_r   <= pat_vld_r;
      s1_idx_r   <= pat_idx_r;
      and_r      <= &pat_r;
      or_r       <= |pat_r;
      ref_all1_r <= (pat_r == {WIDTH{1'b1}}) ^ inj_s;
      ref_nz_r   <= (pat_r != {WIDTH{1'b0}});
`ifdef REDCHK_XOR_EN
      xor_r      <= ^pat_r;
      ref_par_r  <= popcount_lsb(pat_r);
`endif
    end
  end

  // Stage 2 compare: any failing check counts the pattern once
  always_comb begin
    mismatch_s = (and_r != ref_all1_r) || (or_r != ref_nz_r);
`ifdef REDCHK_XOR_EN
    mismatch_s = mismatch_s || (xor_r != ref_par_r);
`endif
  end

  // Result bookkeeping: cleared on start, pass only refreshed on the edge into DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_count       <= {ERR_W{1'b0}};
      first_err_valid <= 1'b0;
      first_err_idx   <= {IDX_W{1'b0}};
      pass            <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      err_count       <= {ERR_W{1'b0}};
      first_err_valid <= 1'b0;
      first_err_idx   <= {IDX_W{1'b0}};
      pass            <= 1'b0;
    end else begin
      if (s1_vld_r && mismatch_s) begin
        if (err_count != {ERR_W{1'b1}}) begin
          err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
        end
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= s1_idx_r;
        end
      end
      if ((state_r == DRAIN) && drain_r) begin
        pass <= (err_count == {ERR_W{1'b0}});
      end
    end
  end

endmodule

// File: tb/tb_reduction_self_check.sv
// Bench for reduction_self_check: three instances (68/8, 8/2, 1/8) checked against
// a pattern-level model of ones counts, references and saturating error totals.
module tb_reduction_self_check;

  logic       clk;
  logic       rst_n;
  logic       start_v  [3];
  logic       inject_v [3];
  logic       busy_v   [3];
  logic       done_v   [3];
  logic       pass_v   [3];
  logic       fev_v    [3];
  logic [7:0] err_v    [3];
  logic [6:0] fei_v    [3];

  logic [7:0] err0;
  logic [1:0] err1;
  logic [7:0] err2;
  logic [6:0] fei0;
  logic [3:0] fei1;
  logic [1:0] fei2;

  int  tests;
  int  fails;
  bit  inj_plan [0:127];

  reduction_self_check #(.WIDTH(68), .ERR_W(8)) dut0 (
    .clock(clk), .reset(rst_n), .start(start_v[0]), .inject(inject_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0),
    .first_err_valid(fev_v[0]), .first_err_idx(fei0));

  reduction_self_check #(.WIDTH(8), .ERR_W(2)) dut1 (
    .clock(clk), .reset(rst_n), .start(start_v[1]), .inject(inject_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
    .first_err_valid(fev_v[1]), .first_err_idx(fei1));

  reduction_self_check #(.WIDTH(1), .ERR_W(8)) dut2 (
    .clock(clk), .reset(rst_n), .start(start_v[2]), .inject(inject_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err2),
    .first_err_valid(fev_v[2]), .first_err_idx(fei2));

  assign err_v[0] = err0;
  assign err_v[1] = {6'd0, err1};
  assign err_v[2] = err2;
  assign fei_v[0] = fei0;
  assign fei_v[1] = {3'd0, fei1};
  assign fei_v[2] = {5'd0, fei2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(input int sel);
    case (sel)
      0:       return 68;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int err_max(input int sel);
    return (sel == 1) ? 3 : 255;
  endfunction

  task automatic clear_plan();
    for (int k = 0; k < 128; k++) inj_plan[k] = 1'b0;
  endtask

  // One run on instance sel; extra start pulses at cycles s1/s2 must be ignored
  task automatic run_check(input int sel, input string name, input int s1, input int s2);
    int w, n, cnt, first, exp_err, done_cnt, done_at, busy_bad;
    bit fv;
    w = width_of(sel);
    n = w + 2;
    cnt = 0; fv = 1'b0; first = 0;
    for (int k = 0; k < n; k++) begin
      int ones;
      bit and_o, or_o, ref_a, ref_n;
      ones  = (k == 0) ? 0 : ((k == n - 1) ? w : w - 1);
      and_o = (ones == w);
      or_o  = (ones > 0);
      ref_a = (ones == w) ^ inj_plan[k];
      ref_n = (ones != 0);
      if ((and_o != ref_a) || (or_o != ref_n)) begin
        cnt++;
        if (!fv) begin fv = 1'b1; first = k; end
      end
    end
    exp_err = (cnt > err_max(sel)) ? err_max(sel) : cnt;

    @(negedge clk);
    start_v[sel]  = 1'b1;
    inject_v[sel] = 1'($urandom_range(0, 1));
    done_cnt = 0; done_at = -1; busy_bad = 0;
    for (int c = 1; c <= n + 5; c++) begin
      @(negedge clk);
      start_v[sel]  = (c == s1) || (c == s2);
      inject_v[sel] = (c <= n) ? inj_plan[c - 1] : 1'($urandom_range(0, 1));
      if (busy_v[sel] !== ((c <= n + 3) ? 1'b1 : 1'b0)) busy_bad++;
      if (done_v[sel] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          tests++;
          if (err_v[sel] !== 8'(exp_err)) begin
            fails++; $display("FAIL %s err_count: got %0d want %0d", name, err_v[sel], exp_err);
          end
          tests++;
          if (pass_v[sel] !== (exp_err == 0)) begin
            fails++; $display("FAIL %s pass: got %b want %b", name, pass_v[sel], exp_err == 0);
          end
          tests++;
          if (fev_v[sel] !== fv) begin
            fails++; $display("FAIL %s first_err_valid: got %b want %b", name, fev_v[sel], fv);
          end
          tests++;
          if (fei_v[sel] !== 7'(first)) begin
            fails++; $display("FAIL %s first_err_idx: got %0d want %0d", name, fei_v[sel], first);
          end
        end
      end
    end
    start_v[sel]  = 1'b0;
    inject_v[sel] = 1'b0;
    tests++;
    if (done_at != n + 3 || done_cnt != 1) begin
      fails++; $display("FAIL %s done: at cycle %0d count %0d, want cycle %0d count 1", name, done_at, done_cnt, n + 3);
    end
    tests++;
    if (busy_bad != 0) begin
      fails++; $display("FAIL %s busy: %0d wrong cycles, want 0", name, busy_bad);
    end
    tests++;
    if (pass_v[sel] !== (exp_err == 0)) begin
      fails++; $display("FAIL %s pass_hold: got %b want %b", name, pass_v[sel], exp_err == 0);
    end
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || pass_v[s] !== 1'b0 ||
          err_v[s] !== 8'd0 || fev_v[s] !== 1'b0 || fei_v[s] !== 7'd0) begin
        fails++;
        $display("FAIL reset[%0d]: busy %b done %b pass %b err %0d fev %b fei %0d, want all 0",
                 s, busy_v[s], done_v[s], pass_v[s], err_v[s], fev_v[s], fei_v[s]);
      end
    end
  endtask

  task automatic test_clean();
    clear_plan();
    run_check(0, "clean_w68", -1, -1);
    run_check(2, "clean_w1", -1, -1);
  endtask

  task automatic test_inject_last();
    clear_plan();
    inj_plan[69] = 1'b1;
    run_check(0, "inject_k69", -1, -1);
    clear_plan();
    inj_plan[2] = 1'b1;
    run_check(2, "inject_w1_k2", -1, -1);
  endtask

  task automatic test_saturation();
    clear_plan();
    for (int k = 0; k < 10; k++) inj_plan[k] = 1'b1;
    run_check(1, "saturate_w8", -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      clear_plan();
      for (int k = 0; k < 70; k++) inj_plan[k] = ($urandom_range(0, 7) == 0);
      run_check(r % 3, "random", -1, -1);
    end
  endtask

  task automatic test_start_ignored();
    clear_plan();
    inj_plan[10] = 1'b1;
    inj_plan[50] = 1'b1;
    run_check(0, "start_ignored", 5, 40);
  endtask

  // start held high on the WIDTH=1 instance: done at cycle 6, next run's done at 13
  task automatic test_start_held();
    int d1, d2, dn;
    d1 = -1; d2 = -1; dn = 0;
    @(negedge clk);
    start_v[2] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done_v[2] === 1'b1) begin
        dn++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
    end
    start_v[2] = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (dn != 2 || d1 != 6 || d2 != 13) begin
      fails++; $display("FAIL start_held: done count %0d at %0d,%0d want 2 at 6,13", dn, d1, d2);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    clear_plan();
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_v[0]  = 1'b0;
      inject_v[0] = (c == 3);
    end
    inject_v[0] = 1'b0;
    tests++;
    if (err_v[0] !== 8'd1 || busy_v[0] !== 1'b1) begin
      fails++; $display("FAIL pre_reset: err %0d busy %b want 1 1", err_v[0], busy_v[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || pass_v[0] !== 1'b0 ||
        err_v[0] !== 8'd0 || fev_v[0] !== 1'b0 || fei_v[0] !== 7'd0) begin
      fails++;
      $display("FAIL async_reset: busy %b done %b pass %b err %0d fev %b fei %0d, want all 0",
               busy_v[0], done_v[0], pass_v[0], err_v[0], fev_v[0], fei_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL reset_abort: %0d cycles with busy/done after abort, want 0", bad);
    end
    run_check(0, "after_reset", -1, -1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      start_v[s]  = 1'b0;
      inject_v[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_clean();
    test_inject_last();
    test_saturation();
    test_start_ignored();
    test_start_held();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
